// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Word/instruction typedefs, fetch FSM states and the sequential-PC helper.
package if_fetch_pkg;

  typedef logic        Bit_t;
  typedef logic [31:0] Word_t;
  typedef logic [31:0] Inst_t;

  localparam Word_t RESET_PC_DEF = 32'hBFC0_0000;
  localparam Word_t ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } FetchState_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic Word_t seq_pc(input Word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} skid buffer that catches a fetched word while ID is stalled.
// clear wins over push, push wins over pop.
module if_skid_buf
  import if_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  Bit_t  clear_i,
  input  Bit_t  push_i,
  input  Bit_t  pop_i,
  input  Word_t pc_i,
  input  Inst_t inst_i,
  output Bit_t  full_o,
  output Word_t pc_o,
  output Inst_t inst_o
);

  Bit_t  full_q, full_d;
  Word_t pc_q;
  Inst_t inst_q;

  always_comb begin
    full_d = full_q;
    if (pop_i)   full_d = 1'b0;
    if (push_i)  full_d = 1'b1;
    if (clear_i) full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  // Payload is qualified by full_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_i) begin
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end
  end

  assign full_o = full_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/if_fetch.sv
// MIPS IF stage: owns the PC, drives a single-outstanding instruction bus and
// feeds {pc, inst, valid} to ID with stall, delay-slot branch and flush support.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter Word_t RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  input  logic        id_stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  FetchState_t state_q, state_d;
  Word_t       pc_q, pc_d;
  Bit_t        req_q, req_d;
  Bit_t        redir_q, redir_d;
  Word_t       tgt_q, tgt_d;
  Word_t       fpc_q, fpc_d;
  Bit_t        vld_q, vld_d;
  Word_t       id_pc_q, id_pc_d;
  Inst_t       id_inst_q, id_inst_d;

  Bit_t  skid_push, skid_pop, skid_clear, skid_full;
  Word_t skid_pc;
  Inst_t skid_inst;

  Bit_t  out_free, acked;
  Word_t next_pc;

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear_i (skid_clear),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .pc_i    (pc_q),
    .inst_i  (ibus_rdata),
    .full_o  (skid_full),
    .pc_o    (skid_pc),
    .inst_o  (skid_inst)
  );

  assign out_free = !vld_q || !id_stall;
  assign acked    = req_q && ibus_ack;

  // A branch arriving with the ack makes the acked word the delay slot.
  always_comb begin
    next_pc = seq_pc(pc_q);
    if (branch_flag)  next_pc = branch_target;
    else if (redir_q) next_pc = tgt_q;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_d    = redir_q;
    tgt_d      = tgt_q;
    fpc_d      = fpc_q;
    vld_d      = vld_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;

    if (flush) begin
      vld_d      = 1'b0;
      skid_clear = 1'b1;
      redir_d    = 1'b0;
      if (req_q && !ibus_ack) begin
        // The outstanding request cannot be withdrawn; drain it first.
        state_d = DISCARD;
        fpc_d   = flush_pc;
      end else begin
        state_d = FETCH;
        pc_d    = flush_pc;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (acked) begin
            pc_d    = next_pc;
            redir_d = 1'b0;
            if (out_free) begin
              vld_d     = 1'b1;
              id_pc_d   = pc_q;
              id_inst_d = ibus_rdata;
            end else begin
              skid_push = 1'b1;
              state_d   = HOLD;
            end
          end else begin
            if (out_free) vld_d = 1'b0;
            if (branch_flag) begin
              redir_d = 1'b1;
              tgt_d   = branch_target;
            end
          end
        end
        HOLD: begin
          // The skid already holds the delay slot, so jump straight to target.
          if (branch_flag) begin
            pc_d    = branch_target;
            redir_d = 1'b0;
          end
          if (out_free && skid_full) begin
            vld_d     = 1'b1;
            id_pc_d   = skid_pc;
            id_inst_d = skid_inst;
            skid_pop  = 1'b1;
            state_d   = FETCH;
          end
        end
        DISCARD: begin
          if (out_free) vld_d = 1'b0;
          if (acked) begin
            pc_d    = fpc_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end

    req_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      redir_q   <= 1'b0;
      vld_q     <= 1'b0;
      id_pc_q   <= ZERO_WORD;
      id_inst_q <= ZERO_WORD;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      redir_q   <= redir_d;
      vld_q     <= vld_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
    end
  end

  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
    fpc_q <= fpc_d;
  end

  assign ibus_req  = req_q;
  assign ibus_addr = {pc_q[31:2], 2'b00};
  assign id_valid  = vld_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a variable-latency bus responder, a consumption
// recorder, and one task per scenario with hand-computed expected PCs.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        id_stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;

  logic [31:0] cap_pc[$];
  logic [31:0] cap_inst[$];

  if_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .ibus_req      (ibus_req),
    .ibus_addr     (ibus_addr),
    .ibus_ack      (ibus_ack),
    .ibus_rdata    (ibus_rdata),
    .id_stall      (id_stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_inst       (id_inst)
  );

  always #5 clk = ~clk;

  // Memory image: each word is its address with the upper half inverted.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hFFFF_0000;
  endfunction

  // Bus responder: acks after 'lat' cycles of a continuously held request.
  initial begin
    int cnt;
    cnt = 0;
    ibus_ack = 1'b0;
    ibus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || ibus_req !== 1'b1) begin
        ibus_ack = 1'b0;
        cnt = 0;
      end else if (cnt >= lat - 1) begin
        ibus_ack = 1'b1;
        ibus_rdata = mem(ibus_addr);
        cnt = 0;
      end else begin
        ibus_ack = 1'b0;
        cnt++;
      end
    end
  end

  // Records every instruction ID actually consumes at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && id_valid === 1'b1 && id_stall === 1'b0 && flush === 1'b0) begin
        cap_pc.push_back(id_pc);
        cap_inst.push_back(id_inst);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_pc.delete();
    cap_inst.delete();
  endtask

  task automatic flush_to(input logic [31:0] a);
    tick();
    flush = 1'b1;
    flush_pc = a;
    @(posedge clk);
    #1;
    flush = 1'b0;
    clear_cap();
  endtask

  task automatic wait_caps(input int n, input string name);
    int b;
    b = 0;
    while (cap_pc.size() < n && b < 200) begin
      tick();
      b++;
    end
    checks++;
    if (cap_pc.size() < n) begin
      failures++;
      $display("FAIL %s_timeout got=%0d deliveries want=%0d", name, cap_pc.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks += 5;
    if (ibus_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", ibus_req); end
    if (ibus_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL reset_addr got=%h want=bfc00000", ibus_addr); end
    if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", id_valid); end
    if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_id_pc got=%h want=00000000", id_pc); end
    if (id_inst !== 32'h0) begin failures++; $display("FAIL reset_id_inst got=%h want=00000000", id_inst); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc[3];
    exp_pc = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
    lat = 1;
    rst = 1'b0;
    clear_cap();
    tick();
    checks += 2;
    if (ibus_req !== 1'b1) begin failures++; $display("FAIL seq_first_req got=%b want=1", ibus_req); end
    if (ibus_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL seq_first_addr got=%h want=bfc00000", ibus_addr); end
    wait_caps(3, "seq");
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (cap_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL seq_pc[%0d] got=%h want=%h", i, cap_pc[i], exp_pc[i]); end
      if (cap_inst[i] !== mem(exp_pc[i])) begin failures++; $display("FAIL seq_inst[%0d] got=%h want=%h", i, cap_inst[i], mem(exp_pc[i])); end
    end
  endtask

  task automatic test_latency();
    logic        prev_req, prev_ack, prev_vld;
    logic [31:0] prev_addr;
    int viol, vv, n1004;
    logic [31:0] exp_pc[3];
    exp_pc = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
    lat = 3;
    flush_to(32'h0000_1000);
    prev_req = 1'b0; prev_ack = 1'b0; prev_vld = 1'b0; prev_addr = '0;
    viol = 0; vv = 0; n1004 = 0;
    for (int i = 0; i < 60 && cap_pc.size() < 3; i++) begin
      tick();
      if (prev_req && !prev_ack && ibus_req && ibus_addr !== prev_addr) viol++;
      if (prev_vld && id_valid) vv++;
      if (ibus_req && ibus_addr == 32'h0000_1004) n1004++;
      prev_req = ibus_req; prev_ack = ibus_ack; prev_vld = id_valid; prev_addr = ibus_addr;
    end
    wait_caps(3, "lat");
    checks += 3;
    if (viol != 0) begin failures++; $display("FAIL lat_addr_stable got=%0d changes want=0", viol); end
    if (vv != 0) begin failures++; $display("FAIL lat_valid_gap got=%0d back-to-back want=0", vv); end
    if (n1004 != 3) begin failures++; $display("FAIL lat_addr_cycles got=%0d want=3", n1004); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL lat_pc[%0d] got=%h want=%h", i, cap_pc[i], exp_pc[i]); end
    end
  endtask

  task automatic test_stall();
    int b;
    logic [31:0] exp_pc[4];
    exp_pc = '{32'h0000_2000, 32'h0000_2004, 32'h0000_2008, 32'h0000_200C};
    lat = 1;
    flush_to(32'h0000_2000);
    b = 0;
    while (!(id_valid === 1'b1 && id_pc === 32'h0000_2000) && b < 50) begin tick(); b++; end
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 3;
      if (ibus_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d] got=%b want=0", i, ibus_req); end
      if (id_pc !== 32'h0000_2000) begin failures++; $display("FAIL stall_id_pc[%0d] got=%h want=00002000", i, id_pc); end
      if (id_inst !== mem(32'h0000_2000)) begin failures++; $display("FAIL stall_id_inst[%0d] got=%h want=%h", i, id_inst, mem(32'h0000_2000)); end
    end
    id_stall = 1'b0;
    wait_caps(4, "stall");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL stall_pc[%0d] got=%h want=%h", i, cap_pc[i], exp_pc[i]); end
    end
  endtask

  task automatic test_branch();
    int b;
    logic [31:0] exp_pc[6];
    exp_pc = '{32'h8000_0008, 32'h8000_000C, 32'h8000_0010,
               32'h8000_0014, 32'h8000_0100, 32'h8000_0104};
    lat = 1;
    flush_to(32'h8000_0008);
    b = 0;
    while (!(id_valid === 1'b1 && id_pc === 32'h8000_0010) && b < 50) begin tick(); b++; end
    branch_flag = 1'b1;
    branch_target = 32'h8000_0100;
    @(posedge clk);
    #1;
    branch_flag = 1'b0;
    wait_caps(6, "branch");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL branch_pc[%0d] got=%h want=%h", i, cap_pc[i], exp_pc[i]); end
    end
  endtask

  task automatic test_flush();
    int b, viol;
    logic [31:0] old_addr;
    logic [31:0] exp_pc[3];
    exp_pc = '{32'hBFC0_0380, 32'hBFC0_0384, 32'hBFC0_0388};
    lat = 3;
    flush_to(32'h0000_3000);
    wait_caps(1, "flush_pre");
    b = 0;
    while (!(ibus_req === 1'b1 && ibus_ack === 1'b0) && b < 20) begin tick(); b++; end
    old_addr = ibus_addr;
    flush = 1'b1;
    flush_pc = 32'hBFC0_0380;
    branch_flag = 1'b1;
    branch_target = 32'h1234_0000;
    @(posedge clk);
    #1;
    flush = 1'b0;
    branch_flag = 1'b0;
    clear_cap();
    tick();
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b want=0", id_valid); end
    viol = 0;
    b = 0;
    while (ibus_ack !== 1'b1 && b < 20) begin
      if (ibus_req !== 1'b1 || ibus_addr !== old_addr) viol++;
      tick();
      b++;
    end
    checks++;
    if (viol != 0 || ibus_addr !== old_addr) begin
      failures++;
      $display("FAIL flush_hold got=%0d changes addr=%h want=0 addr=%h", viol, ibus_addr, old_addr);
    end
    tick();
    checks += 3;
    if (ibus_addr !== 32'hBFC0_0380) begin failures++; $display("FAIL flush_addr got=%h want=bfc00380", ibus_addr); end
    if (ibus_req !== 1'b1) begin failures++; $display("FAIL flush_req got=%b want=1", ibus_req); end
    if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%b want=0", id_valid); end
    wait_caps(3, "flush");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL flush_pc[%0d] got=%h want=%h", i, cap_pc[i], exp_pc[i]); end
    end
  endtask

  task automatic test_reset_in_hold();
    int b;
    lat = 1;
    flush_to(32'h0000_4000);
    b = 0;
    while (!(id_valid === 1'b1 && id_pc === 32'h0000_4000) && b < 50) begin tick(); b++; end
    id_stall = 1'b1;
    tick();
    tick();
    checks++;
    if (ibus_req !== 1'b0) begin failures++; $display("FAIL rsthold_setup_req got=%b want=0", ibus_req); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_cap();
    tick();
    checks += 3;
    if (ibus_req !== 1'b0) begin failures++; $display("FAIL rsthold_req got=%b want=0", ibus_req); end
    if (id_valid !== 1'b0) begin failures++; $display("FAIL rsthold_valid got=%b want=0", id_valid); end
    if (ibus_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL rsthold_addr got=%h want=bfc00000", ibus_addr); end
    rst = 1'b0;
    id_stall = 1'b0;
    tick();
    checks += 2;
    if (ibus_req !== 1'b1) begin failures++; $display("FAIL rsthold_refetch_req got=%b want=1", ibus_req); end
    if (ibus_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL rsthold_refetch_addr got=%h want=bfc00000", ibus_addr); end
    wait_caps(2, "rsthold");
    checks += 2;
    if (cap_pc[0] !== 32'hBFC0_0000) begin failures++; $display("FAIL rsthold_pc0 got=%h want=bfc00000", cap_pc[0]); end
    if (cap_pc[1] !== 32'hBFC0_0004) begin failures++; $display("FAIL rsthold_pc1 got=%h want=bfc00004", cap_pc[1]); end
  endtask

  initial begin
    rst = 1'b1;
    id_stall = 1'b0;
    branch_flag = 1'b0;
    branch_target = 32'h0;
    flush = 1'b0;
    flush_pc = 32'h0;
    test_reset();
    test_sequential();
    test_latency();
    test_stall();
    test_branch();
    test_flush();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the ID stage.
- Owns the PC and drives a single-outstanding-request instruction bus with variable latency.
- Delivers {pc, inst, valid} to ID.
- Honours ID back-pressure (stall), branch redirects with one delay slot, and exception flushes.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ibus_req  out  1  fetch request; held high with ibus_addr stable until ibus_ack.
- ibus_addr  out  32  word-aligned fetch address.
- ibus_ack  in  1  one-cycle pulse; ibus_rdata is valid in the same cycle.
- ibus_rdata  in  32  fetched instruction word.
- id_stall  in  1  ID cannot consume the current output this cycle.
- branch_flag  in  1  one-cycle pulse from ID: taken branch/jump accepted.
- branch_target  in  32  redirect address, valid with branch_flag.
- flush  in  1  one-cycle pulse: exception/ERET flush.
- flush_pc  in  32  restart address, valid with flush.
- id_valid  out  1  id_inst/id_pc hold a live instruction.
- id_pc  out  32  PC of id_inst.
- id_inst  out  32  instruction word to ID decode.

Behaviour:
- Reset values: ibus_req=0, ibus_addr=RESET_PC, id_valid=0, id_pc=0, id_inst=0 (NOP). Internal pc=RESET_PC, state=FETCH, skid buffer empty, redirect-pending=0.
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, and overrides every other input in the same cycle, including mid-request. The bus must tolerate a dropped request at reset.
- Bus rules:
  - ibus_req and ibus_addr must not change while a request is outstanding (req=1, no ack yet).
  - Only one request is outstanding at a time.
  - A new request may start in the cycle after an ack.
- Output register consumption: the output register is "free" when id_valid=0 or id_stall=0.
- State FETCH:
  - ibus_req=1, ibus_addr=pc.
  - On ack with output free: id_inst<=rdata, id_pc<=pc, id_valid<=1, and pc advances to the next PC.
  - On ack with output not free: {pc, rdata} goes into the skid buffer, and the state goes to HOLD.
  - If no ack and the output is free, id_valid<=0.
- State HOLD:
  - ibus_req=0.
  - When the output becomes free, the buffer moves to the output register, the buffer empties, and the state returns to FETCH.
- State DISCARD:
  - Entered when flush arrives while a request is outstanding.
  - ibus_req stays 1 with the old address until ack; the ack data is dropped.
  - Then pc<=the saved flush_pc, and the state goes to FETCH.
- Next PC: pc+4 (wraps modulo 2^32). If redirect-pending is set, next PC = the saved target and redirect-pending clears.
- Branch:
  - branch_flag latches branch_target and sets redirect-pending.
  - The fetch in flight, or the next fetch, supplies the delay slot at branch_pc+4 and is never killed.
  - The PC after the delay slot is the target.
  - If branch_flag coincides with an ack in FETCH, the acked word is the delay slot and the new pc becomes the target directly.
- Flush:
  - Clears id_valid, the skid buffer, and redirect-pending in the same edge.
  - With no request outstanding (HOLD, or FETCH on the ack cycle), pc<=flush_pc and the state goes to FETCH.
  - With a request outstanding, the state goes to DISCARD.
  - Flush has priority over branch_flag and ack in the same cycle.
- id_stall held with id_valid=1: id_pc and id_inst are held unchanged.

Decomposition:
- Add to cpu_defines.svh:
  - `RESET_PC` macro.
  - FetchState_t enum {FETCH, HOLD, DISCARD}.
  - Reuse Word_t, Inst_t, Bit_t.
  - Define `ZERO_WORD` if absent.
- One sub-module, if_skid_buf: a one-entry {pc, inst} buffer with push/pop/full/clear.

Test Plan:
- Reset, 1-cycle-ack bus, no stall -> first req addr 0xBFC00000; id_pc sequence 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive acks; id_valid=1 after the first ack.
- 3-cycle ack latency -> ibus_addr stable for 3 cycles; id_valid=0 between acks; no skipped PCs.
- id_stall=1 for 4 cycles while an ack arrives -> id_inst held; skid captures the next word; ibus_req=0 in HOLD; after release, the buffered pc+4 is delivered, then fetch resumes at pc+8.
- branch_flag at ID pc 0x80000010 with target 0x80000100 -> delivered sequence ...0x80000010, 0x80000014 (delay slot), 0x80000100, 0x80000104.
- flush with flush_pc=0xBFC00380 while a request is outstanding -> req held until ack, data dropped, id_valid=0, next addr 0xBFC00380; a simultaneous branch_flag is ignored.
- rst asserted mid-request in HOLD -> next cycle ibus_req=0, id_valid=0, then refetch at 0xBFC00000.
